cnt_compare: RTL

- Compare/capture stage directly downstream of the free-running counter; consumes its count value every cycle.
- Generates a compare-match pulse, a PWM level and a wrap pulse, using a double-buffered compare register.
- Captures the count on an external event into a one-entry valid/ready buffer for a downstream consumer.

---
 rtl/cnt_pkg.sv | 15 +
 rtl/cnt_compare_if.sv | 22 ++
 rtl/cnt_capture_buf.sv | 69 ++++++
 rtl/cnt_compare.sv | 98 +++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the counter compare/capture slice.
//   CNT_WIDTH   : default width of count, compare and capture data
//   CMP_RST_DEF : default reset value of the compare registers
//   cap_state_t : states of the one-entry capture buffer
package cnt_pkg;

  localparam int CNT_WIDTH   = 8;
  localparam int CMP_RST_DEF = 128;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_FULL = 1'b1
  } cap_state_t;

endpackage

// File: rtl/cnt_compare_if.sv
// Capture handshake between cnt_compare (producer) and its consumer.
//   cap_valid : captured data available (producer -> consumer)
//   cap_data  : captured count value     (producer -> consumer)
//   cap_ready : consumer accepts data    (consumer -> producer)
// Handshake: a transfer happens on a rising clk edge where cap_valid and
// cap_ready are both 1. While cap_valid=1 and cap_ready=0 the producer holds
// cap_data stable and keeps cap_valid asserted; cap_ready may be asserted
// independently of cap_valid.
interface cnt_compare_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
);

  logic             cap_valid;
  logic             cap_ready;
  logic [WIDTH-1:0] cap_data;

  modport master (output cap_valid, output cap_data, input cap_ready);
  modport slave  (input cap_valid, input cap_data, output cap_ready);

endinterface

// File: rtl/cnt_capture_buf.sv
// One-entry capture buffer: snapshots the count on cap_evt and holds it for
// a valid/ready consumer. An event arriving while the entry is full and not
// being drained is dropped and flagged in the sticky cap_ovf.
//   clk, res  : clock, async active-low reset
//   value     : current count from the upstream counter
//   cap_evt   : capture request (synchronous to clk)
//   cap_ready : consumer ready
//   ovf_clr   : clears cap_ovf (a simultaneous drop wins)
//   cap_valid : entry holds data
//   cap_data  : captured count
//   cap_ovf   : sticky dropped-event flag
//   state     : FSM state, exported for observation
module cnt_capture_buf
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] value,
  input  logic             cap_evt,
  input  logic             cap_ready,
  input  logic             ovf_clr,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_ovf,
  output cap_state_t       state
);

  logic drop;

  // A full entry that is being drained this cycle can take the new event
  // in place of the old one, so only a non-drained full entry drops.
  assign drop = (state == CAP_FULL) && cap_evt && !cap_ready;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= CAP_IDLE;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_ovf   <= 1'b0;
    end else begin
      if (state == CAP_IDLE) begin
        if (cap_evt) begin
          cap_data  <= value;
          cap_valid <= 1'b1;
          state     <= CAP_FULL;
        end
      end else begin
        if (cap_ready) begin
          if (cap_evt) begin
            // Back-to-back: old entry handed off, new one loaded.
            cap_data <= value;
          end else begin
            cap_valid <= 1'b0;
            state     <= CAP_IDLE;
          end
        end
      end

      if (drop) begin
        cap_ovf <= 1'b1;
      end else if (ovf_clr) begin
        cap_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cnt_compare.sv
// Compare/capture stage fed by a free-running counter. Produces a compare
// match pulse, a PWM level and a wrap pulse from a double-buffered compare
// register, and captures the count on an external event.
//   clk, res  : clock, async active-low reset
//   value     : count from upstream counter, consumed every cycle
//   cmp_wr    : load cmp_data into the compare shadow register
//   cmp_data  : new compare value
//   cap_evt   : capture event
//   ovf_clr   : clear sticky cap_ovf
//   cap       : capture handshake (cap_valid, cap_data out; cap_ready in)
//   match     : one-cycle pulse when the count arrives at the compare value
//   pwm       : high while count < active compare value
//   wrap      : one-cycle pulse after the count wraps
//   cap_ovf   : sticky, a capture event was dropped
//   cap_state : capture FSM state, exported for observation
module cnt_compare
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int CMP_RST = CMP_RST_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] value,
  input  logic             cmp_wr,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic             cap_evt,
  input  logic             ovf_clr,
  cnt_compare_if.master    cap,
  output logic             match,
  output logic             pwm,
  output logic             wrap,
  output logic             cap_ovf,
  output cap_state_t       cap_state
);

  localparam logic [WIDTH-1:0] CMP_RST_V = WIDTH'(CMP_RST);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] shadow_q;
  logic             pending;
  logic             wrap_det;

  // The count only ever moves upward except when it wraps, so a drop
  // against last cycle's value marks the period boundary.
  assign wrap_det = value < val_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      val_q    <= '0;
      active_q <= CMP_RST_V;
      shadow_q <= CMP_RST_V;
      pending  <= 1'b0;
      match    <= 1'b0;
      pwm      <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      val_q <= value;
      wrap  <= wrap_det;
      // Requiring a change of count keeps match from repeating while the
      // counter is held at the compare value.
      match <= (value == active_q) && (value != val_q);
      pwm   <= value < active_q;

      // New compare values take effect only at a period boundary so a
      // PWM period is never truncated. A write landing exactly on the
      // boundary goes straight to the active register.
      if (cmp_wr && wrap_det) begin
        active_q <= cmp_data;
        shadow_q <= cmp_data;
        pending  <= 1'b0;
      end else if (cmp_wr) begin
        shadow_q <= cmp_data;
        pending  <= 1'b1;
      end else if (wrap_det && pending) begin
        active_q <= shadow_q;
        pending  <= 1'b0;
      end
    end
  end

  cnt_capture_buf #(
    .WIDTH (WIDTH)
  ) u_capture (
    .clk       (clk),
    .res       (res),
    .value     (value),
    .cap_evt   (cap_evt),
    .cap_ready (cap.cap_ready),
    .ovf_clr   (ovf_clr),
    .cap_valid (cap.cap_valid),
    .cap_data  (cap.cap_data),
    .cap_ovf   (cap_ovf),
    .state     (cap_state)
  );

endmodule
